// File: rtl/controle_neander_pit.sv
// ---------------------------------------------------------------------------
// ControleNeanderPit -- control unit for the extended 8-bit Neander
// accumulator machine (PC, REM, AC, ROM/RAM memory, ALU).
//
// It steps through fetch, operand read and execute for eleven instructions.
// It also keeps the N/Z flag registers, a halt state that can be restarted,
// and a counter of retired instructions.
//
// Ports
//   clk       : system clock, every register updates on the rising edge
//   rst       : asynchronous, active-low reset
//   inst_in   : opcode nibble, taken from memory dout[7:4]
//   alu_res   : ALU result (AC D-input), used to update N/Z when AC loads
//   go        : restart request, only looked at while halted
//   selPC     : PC mux select (1 = PC+1, 0 = memory dout)
//   enPC      : PC load enable
//   selMEM    : address mux select (1 = PC, 0 = REM)
//   enREM     : REM load enable
//   write     : memory write strobe
//   opULA     : ALU operation (000 pass, 001 add, 010 or, 011 and, 100 not)
//   enAC      : AC load enable
//   flag_n    : registered negative flag
//   flag_z    : registered zero flag
//   halted    : high while the machine sits in HALT
//   oEA       : current state code, for debugging
//   inst_cnt  : retired-instruction counter, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module controle_neander_pit #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       inst_in,
   input  logic [7:0]       alu_res,
   input  logic             go,
   output logic             selPC,
   output logic             enPC,
   output logic             selMEM,
   output logic             enREM,
   output logic             write,
   output logic [2:0]       opULA,
   output logic             enAC,
   output logic             flag_n,
   output logic             flag_z,
   output logic             halted,
   output logic [3:0]       oEA,
   output logic [CNT_W-1:0] inst_cnt
);

   typedef enum logic [3:0] {
      S_FETCH = 4'd0,
      S_OPER  = 4'd1,
      S_JTAKE = 4'd2,
      S_JSKIP = 4'd3,
      S_LDA   = 4'd4,
      S_ADD   = 4'd5,
      S_OR    = 4'd6,
      S_AND   = 4'd7,
      S_STA   = 4'd8,
      S_NOT   = 4'd9,
      S_HALT  = 4'd15
   } state_t;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_STA = 4'b0001;
   localparam logic [3:0] OP_LDA = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_OR  = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b0110;
   localparam logic [3:0] OP_JMP = 4'b1000;
   localparam logic [3:0] OP_JN  = 4'b1001;
   localparam logic [3:0] OP_JZ  = 4'b1010;

   state_t           state_q, state_d;
   logic [3:0]       ir_q;
   logic             flagN_q, flagZ_q;
   logic [CNT_W-1:0] instCnt_q;
   logic             retire;

   // State register. An asynchronous reset aborts any instruction in
   // progress and puts the machine back at FETCH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode. The opcode is decoded straight from memory during
   // FETCH, so single-cycle NOP and two-cycle jumps need no extra decode
   // state. The OPER state dispatches on the latched IR, because by then
   // memory shows the operand byte. Conditional jumps use the flags as
   // registered at this edge. "retire" marks the final edge of every
   // non-HLT instruction.
   always_comb begin
      state_d = S_HALT;
      retire  = 1'b0;
      case (state_q)
         S_FETCH: begin
            case (inst_in)
               OP_NOP: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               OP_NOT:  state_d = S_NOT;
               OP_JMP:  state_d = S_JTAKE;
               OP_JN:   state_d = flagN_q ? S_JTAKE : S_JSKIP;
               OP_JZ:   state_d = flagZ_q ? S_JTAKE : S_JSKIP;
               OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND: state_d = S_OPER;
               default: state_d = S_HALT;
            endcase
         end
         S_OPER: begin
            case (ir_q)
               OP_LDA:  state_d = S_LDA;
               OP_ADD:  state_d = S_ADD;
               OP_OR:   state_d = S_OR;
               OP_AND:  state_d = S_AND;
               OP_STA:  state_d = S_STA;
               default: state_d = S_HALT;
            endcase
         end
         S_JTAKE, S_JSKIP, S_LDA, S_ADD, S_OR, S_AND, S_STA, S_NOT: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_HALT: begin
            state_d = go ? S_FETCH : S_HALT;
         end
         default: begin
            state_d = S_HALT;
         end
      endcase
   end

   // Output decode. The outputs depend only on the state, and every output
   // is forced low while reset is held. This blocks a write strobe as soon
   // as reset falls, instead of waiting for the state register to settle.
   always_comb begin
      selPC  = 1'b0;
      enPC   = 1'b0;
      selMEM = 1'b0;
      enREM  = 1'b0;
      write  = 1'b0;
      opULA  = 3'b000;
      enAC   = 1'b0;
      halted = 1'b0;
      if (rst) begin
         case (state_q)
            S_FETCH: begin
               selMEM = 1'b1;
               selPC  = 1'b1;
               enPC   = 1'b1;
            end
            S_OPER: begin
               selMEM = 1'b1;
               selPC  = 1'b1;
               enPC   = 1'b1;
               enREM  = 1'b1;
            end
            S_JTAKE: begin
               selMEM = 1'b1;
               enPC   = 1'b1;
            end
            S_JSKIP: begin
               selPC  = 1'b1;
               enPC   = 1'b1;
            end
            S_LDA: begin
               opULA  = 3'b000;
               enAC   = 1'b1;
            end
            S_ADD: begin
               opULA  = 3'b001;
               enAC   = 1'b1;
            end
            S_OR: begin
               opULA  = 3'b010;
               enAC   = 1'b1;
            end
            S_AND: begin
               opULA  = 3'b011;
               enAC   = 1'b1;
            end
            S_STA: begin
               write  = 1'b1;
            end
            S_NOT: begin
               opULA  = 3'b100;
               enAC   = 1'b1;
            end
            S_HALT: begin
               halted = 1'b1;
            end
            default: begin
               halted = 1'b0;
            end
         endcase
      end
   end

   // Instruction register. It captures the opcode nibble on every FETCH
   // edge, so OPER can dispatch after memory has moved on to the operand.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir_q <= 4'd0;
      end else if (state_q == S_FETCH) begin
         ir_q <= inst_in;
      end
   end

   // N/Z flags. They follow the value that AC is loading, and they only
   // change on an edge where AC actually loads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flagN_q <= 1'b0;
         flagZ_q <= 1'b1;
      end else if (enAC) begin
         flagN_q <= alu_res[7];
         flagZ_q <= (alu_res == 8'd0);
      end
   end

   // Retired-instruction counter. It wraps freely at its width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instCnt_q <= '0;
      end else if (retire) begin
         instCnt_q <= instCnt_q + CNT_W'(1);
      end
   end

   assign flag_n   = flagN_q;
   assign flag_z   = flagZ_q;
   assign oEA      = state_q;
   assign inst_cnt = instCnt_q;

endmodule

// File: tb/tb_controle_neander_pit.sv
// ---------------------------------------------------------------------------
// tb_controle_neander_pit -- scoreboard bench for controle_neander_pit.
//
// The stimulus drives one cycle at a time. For each cycle it pushes the
// hand-computed observation expected during that cycle. A monitor on the
// falling edge pops each entry and compares it with the DUTs.
//
// A second instance with CNT_W=2 shares every input with the first, so
// counter wrap is checked alongside the main run.
// ---------------------------------------------------------------------------
module tb_controle_neander_pit;

   logic       clk;
   logic       rst;
   logic [3:0] instIn;
   logic [7:0] aluRes;
   logic       goIn;

   logic       selPC, enPC, selMEM, enREM, writeS, enAC, flagN, flagZ, haltedS;
   logic [2:0] opULA;
   logic [3:0] oEA;
   logic [7:0] instCnt;

   logic       selPC2, enPC2, selMEM2, enREM2, writeS2, enAC2, flagN2, flagZ2, halted2;
   logic [2:0] opULA2;
   logic [3:0] oEA2;
   logic [1:0] instCnt2;

   // {selPC, enPC, selMEM, enREM, write, opULA[2:0], enAC}
   localparam logic [8:0] C_NONE  = 9'b0_0_0_0_0_000_0;
   localparam logic [8:0] C_FETCH = 9'b1_1_1_0_0_000_0;
   localparam logic [8:0] C_OPER  = 9'b1_1_1_1_0_000_0;
   localparam logic [8:0] C_JTAKE = 9'b0_1_1_0_0_000_0;
   localparam logic [8:0] C_JSKIP = 9'b1_1_0_0_0_000_0;
   localparam logic [8:0] C_LDA   = 9'b0_0_0_0_0_000_1;
   localparam logic [8:0] C_ADD   = 9'b0_0_0_0_0_001_1;
   localparam logic [8:0] C_STA   = 9'b0_0_0_0_1_000_0;
   localparam logic [8:0] C_NOT   = 9'b0_0_0_0_0_100_1;

   typedef struct {
      string       tag;
      logic [25:0] val;
   } expT;

   expT        expQ[$];
   int         checks;
   int         errors;
   logic       expN;
   logic       expZ;
   logic [7:0] expCnt;
   logic [25:0] obs;

   controle_neander_pit #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .inst_in(instIn), .alu_res(aluRes), .go(goIn),
      .selPC(selPC), .enPC(enPC), .selMEM(selMEM), .enREM(enREM),
      .write(writeS), .opULA(opULA), .enAC(enAC), .flag_n(flagN),
      .flag_z(flagZ), .halted(haltedS), .oEA(oEA), .inst_cnt(instCnt)
   );

   controle_neander_pit #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .inst_in(instIn), .alu_res(aluRes), .go(goIn),
      .selPC(selPC2), .enPC(enPC2), .selMEM(selMEM2), .enREM(enREM2),
      .write(writeS2), .opULA(opULA2), .enAC(enAC2), .flag_n(flagN2),
      .flag_z(flagZ2), .halted(halted2), .oEA(oEA2), .inst_cnt(instCnt2)
   );

   // Everything compared each cycle, packed as one vector.
   assign obs = {oEA, selPC, enPC, selMEM, enREM, writeS, opULA, enAC,
                 flagN, flagZ, haltedS, instCnt, instCnt2};

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Last-resort guard in case the run ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [25:0 ] expV, input logic [25:0] actV);
      checks++;
      if (actV !== expV) begin
         errors++;
         $display("[TB] FAIL %s: got %h required %h (oEA got %0d want %0d)",
                  tag, actV, expV, actV[25:22], expV[25:22]);
      end
   endtask

   // Monitor: on the falling edge, pop the oldest expectation and compare it.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         expT e;
         e = expQ.pop_front();
         checkOutput(e.tag, e.val, obs);
      end
   end

   function automatic logic [25:0] buildExp(input logic [3:0] ea, input logic [8:0] ctrl,
                                            input logic halt);
      return {ea, ctrl, expN, expZ, halt, expCnt, expCnt[1:0]};
   endfunction

   task automatic pushExpect(input string tag, input logic [3:0] ea, input logic [8:0] ctrl,
                             input logic halt);
      expT e;
      e.tag = tag;
      e.val = buildExp(ea, ctrl, halt);
      expQ.push_back(e);
   endtask

   // Drive one cycle's inputs, record what that cycle must show, and
   // advance to just after the next rising edge.
   task automatic applyStimulus(input string tag, input logic [3:0] inst, input logic [7:0] alu,
                                input logic goV, input logic [3:0] ea, input logic [8:0] ctrl,
                                input logic halt);
      instIn = inst;
      aluRes = alu;
      goIn   = goV;
      pushExpect(tag, ea, ctrl, halt);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      instIn = 4'd0;
      aluRes = 8'd0;
      goIn   = 1'b0;
      expN   = 1'b0;
      expZ   = 1'b1;
      expCnt = 8'd0;

      @(posedge clk);
      #1;
      applyStimulus("reset_state", 4'h0, 8'h00, 1'b0, 4'd0, C_NONE, 1'b0);
      rst = 1'b1;

      // Program: LDA 05; ADD 05; STA 80; HLT
      applyStimulus("lda_fetch", 4'h2, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);
      applyStimulus("lda_oper",  4'h0, 8'h00, 1'b0, 4'd1, C_OPER,  1'b0);
      applyStimulus("lda_exec",  4'h0, 8'h05, 1'b0, 4'd4, C_LDA,   1'b0);
      expZ = 1'b0; expCnt = 8'd1;
      applyStimulus("add_fetch", 4'h3, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);
      applyStimulus("add_oper",  4'h0, 8'h00, 1'b0, 4'd1, C_OPER,  1'b0);
      applyStimulus("add_exec",  4'h0, 8'h0A, 1'b0, 4'd5, C_ADD,   1'b0);
      expCnt = 8'd2;
      applyStimulus("sta_fetch", 4'h1, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);
      applyStimulus("sta_oper",  4'h8, 8'h00, 1'b0, 4'd1, C_OPER,  1'b0);
      applyStimulus("sta_exec",  4'h0, 8'h00, 1'b0, 4'd8, C_STA,   1'b0);
      expCnt = 8'd3;
      applyStimulus("hlt_fetch", 4'hF, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);
      for (int i = 0; i < 5; i++)
         applyStimulus("halt_hold", 4'h0, 8'h00, 1'b0, 4'd15, C_NONE, 1'b1);
      applyStimulus("halt_go", 4'h0, 8'h00, 1'b1, 4'd15, C_NONE, 1'b1);

      // Conditional jumps not taken (flags N=0, Z=0)
      applyStimulus("jz0_fetch", 4'hA, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);
      applyStimulus("jz0_skip",  4'h0, 8'h00, 1'b0, 4'd3, C_JSKIP, 1'b0);
      expCnt = 8'd4;
      applyStimulus("jn0_fetch", 4'h9, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);
      applyStimulus("jn0_skip",  4'h0, 8'h00, 1'b0, 4'd3, C_JSKIP, 1'b0);
      expCnt = 8'd5;

      // NOT producing 0x80 sets N, then JN is taken (go ignored in FETCH)
      applyStimulus("not_fetch", 4'h6, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);
      applyStimulus("not_exec",  4'h0, 8'h80, 1'b0, 4'd9, C_NOT,   1'b0);
      expN = 1'b1; expZ = 1'b0; expCnt = 8'd6;
      applyStimulus("jn1_fetch_go", 4'h9, 8'h00, 1'b1, 4'd0, C_FETCH, 1'b0);
      applyStimulus("jn1_take",     4'h0, 8'h00, 1'b0, 4'd2, C_JTAKE, 1'b0);
      expCnt = 8'd7;

      // LDA of zero sets Z, then JZ is taken
      applyStimulus("lda0_fetch", 4'h2, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);
      applyStimulus("lda0_oper",  4'h0, 8'h00, 1'b0, 4'd1, C_OPER,  1'b0);
      applyStimulus("lda0_exec",  4'h0, 8'h00, 1'b0, 4'd4, C_LDA,   1'b0);
      expN = 1'b0; expZ = 1'b1; expCnt = 8'd8;
      applyStimulus("jz1_fetch", 4'hA, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);
      applyStimulus("jz1_take",  4'h0, 8'h00, 1'b0, 4'd2, C_JTAKE, 1'b0);
      expCnt = 8'd9;

      // Four NOPs: one per cycle; the 2-bit counter wraps 3 -> 0
      for (int i = 0; i < 4; i++) begin
         applyStimulus("nop", 4'h0, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);
         expCnt = expCnt + 8'd1;
      end

      // Undefined opcode halts; go during its FETCH is not remembered
      applyStimulus("undef_fetch_go", 4'h7, 8'h00, 1'b1, 4'd0, C_FETCH, 1'b0);
      for (int i = 0; i < 5; i++)
         applyStimulus("undef_halt_hold", 4'h0, 8'h00, 1'b0, 4'd15, C_NONE, 1'b1);
      applyStimulus("undef_halt_go", 4'h0, 8'h00, 1'b1, 4'd15, C_NONE, 1'b1);

      // Set N, then reset in the middle of STA
      applyStimulus("not2_fetch", 4'h6, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);
      applyStimulus("not2_exec",  4'h0, 8'h80, 1'b0, 4'd9, C_NOT,   1'b0);
      expN = 1'b1; expZ = 1'b0; expCnt = 8'd14;
      applyStimulus("sta2_fetch", 4'h1, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);
      applyStimulus("sta2_oper",  4'h8, 8'h00, 1'b0, 4'd1, C_OPER,  1'b0);
      instIn = 4'h0;
      pushExpect("sta2_exec", 4'd8, C_STA, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      expN = 1'b0; expZ = 1'b1; expCnt = 8'd0;
      checkOutput("rst_write_drop", buildExp(4'd0, C_NONE, 1'b0), obs);
      @(posedge clk);
      #1;
      applyStimulus("rst_hold", 4'h0, 8'h00, 1'b0, 4'd0, C_NONE, 1'b0);
      rst = 1'b1;
      applyStimulus("post_rst_fetch", 4'h0, 8'h00, 1'b0, 4'd0, C_FETCH, 1'b0);

      repeat (2) @(posedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
